// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: AXI burst beat-address generator.
// Takes one burst request and emits one address per beat.
module axi_burst_addr_gen #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int LEN_WIDTH  = 8,
    parameter  int DATA_BYTES = 8,
    localparam int LANE_W     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LEN_WIDTH-1:0]  req_len_i,
    input  logic [2:0]            req_size_i,
    input  logic [1:0]            req_burst_i,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic [ADDR_WIDTH-1:0] beat_addr_o,
    output logic [LANE_W-1:0]     beat_lane_o,
    output logic [LEN_WIDTH-1:0]  beat_idx_o,
    output logic                  beat_last_o,
    output logic                  err_o
);

    if (DATA_BYTES < 1 || DATA_BYTES > 128 ||
        (DATA_BYTES & (DATA_BYTES - 1)) != 0) begin : g_cfg_err
        $error("DATA_BYTES must be a power of 2 in 1..128");
    end

    localparam int SIZE_MAX = $clog2(DATA_BYTES);
    // Wide enough that an INCR end address never wraps.
    localparam int EW       = ADDR_WIDTH + LEN_WIDTH + 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  err_q, err_d;

    logic                  req_hs, beat_hs, illegal;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Request legality, judged on the live request fields.
    always_comb begin
        logic [EW-1:0]         first_w, last_w, step_w;
        logic [ADDR_WIDTH-1:0] low_mask;
        logic                  wrap_len_ok;
        step_w      = EW'(1) << req_size_i;
        first_w     = EW'(req_addr_i);
        last_w      = (first_w & ~(step_w - EW'(1)))
                    + (EW'(req_len_i) << req_size_i)
                    + step_w - EW'(1);
        low_mask    = (ADDR_WIDTH'(1) << req_size_i) - ADDR_WIDTH'(1);
        wrap_len_ok = (req_len_i == LEN_WIDTH'(1)) ||
                      (req_len_i == LEN_WIDTH'(3)) ||
                      (req_len_i == LEN_WIDTH'(7)) ||
                      (req_len_i == LEN_WIDTH'(15));
        illegal = 1'b0;
        if (req_burst_i == 2'd3) illegal = 1'b1;
        if (req_size_i > 3'(SIZE_MAX)) illegal = 1'b1;
        if (req_burst_i == 2'd2) begin
            if (!wrap_len_ok) illegal = 1'b1;
            if ((req_addr_i & low_mask) != '0) illegal = 1'b1;
        end
        if (req_burst_i == 2'd1) begin
            if ((first_w >> 12) != (last_w >> 12)) illegal = 1'b1;
        end
    end

    // Address of the following beat, from latched request only.
    always_comb begin
        logic [ADDR_WIDTH-1:0] step, mask, bnd;
        step = ADDR_WIDTH'(1) << size_q;
        mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q)
             - ADDR_WIDTH'(1);
        bnd  = addr_q & ~mask;
        unique case (burst_q)
            2'd1:    next_addr = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
            2'd2:    next_addr = bnd + ((addr_q - bnd + step) & mask);
            default: next_addr = addr_q;
        endcase
    end

    // Handshake-visible outputs, all gated off while in reset.
    always_comb begin
        req_ready_o  = (state_q == IDLE) && rst_ni;
        beat_valid_o = (state_q == BURST);
        beat_last_o  = beat_valid_o && (idx_q == len_q);
        beat_addr_o  = addr_q;
        beat_idx_o   = idx_q;
        beat_lane_o  = (DATA_BYTES == 1) ? '0 : addr_q[LANE_W-1:0];
        err_o        = err_q;
        req_hs       = req_valid_i && req_ready_o;
        beat_hs      = beat_valid_o && beat_ready_i;
    end

    // Next state: legal request opens a burst, last handshake closes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_hs && !illegal) state_d = BURST;
            BURST:   if (beat_hs && beat_last_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch on accept, step on each non-final beat handshake.
    always_comb begin
        addr_d  = addr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = 1'b0;
        if (req_hs) begin
            err_d   = illegal;
            addr_d  = req_addr_i;
            len_d   = req_len_i;
            size_d  = req_size_i;
            burst_d = req_burst_i;
            idx_d   = '0;
        end else if (beat_hs && !beat_last_o) begin
            addr_d = next_addr;
            idx_d  = idx_q + LEN_WIDTH'(1);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

endmodule
